// File: rtl/proc_clock_ctrl.sv
// proc_clock_ctrl
//   Divides the master clock by DIV to produce the processor/regfile clock and
//   adds run / halt / single-step control that only ever stops the core on a
//   processor-period boundary. The phase index is exported so memory-side logic
//   (which stays on the master clock) can line up with processor edges.
//
//   Optional feature: define PCC_CYCLE_COUNT_EN to add a 32-bit count of
//   completed processor periods (output cycle_count). Without the macro the
//   port and counter do not exist and everything else behaves identically.
//
//   DIV must be a power of two (>= 2) and LOG2DIV = log2(DIV). The phase
//   counter therefore wraps naturally when it overflows its LOG2DIV bits.
module proc_clock_ctrl #(
  parameter int DIV       = 4,
  parameter int LOG2DIV   = 2,
  parameter bit START_RUN = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  output logic               proc_clock,
  output logic               regfile_clock,
  output logic [LOG2DIV-1:0] phase,
  output logic               halted,
  output logic               step_done
`ifdef PCC_CYCLE_COUNT_EN
  ,
  output logic [31:0]        cycle_count
`endif
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // State the controller comes out of reset in.
  localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  // Last phase of a processor period; the step from here back to 0 is the wrap
  // and the only rising edge of proc_clock.
  localparam logic [LOG2DIV-1:0] LAST_PHASE = LOG2DIV'(DIV - 1);

  state_t               state_reg;
  logic [LOG2DIV-1:0]   phase_reg;
  logic                 halt_pend_reg;
  logic                 halted_reg;
  logic                 step_done_reg;

  logic                 wrap;
  logic                 advancing;

  // The phase counter only moves outside HALT; a wrap is the DIV-1 -> 0 step.
  assign advancing = (state_reg != ST_HALT);
  assign wrap      = advancing && (phase_reg == LAST_PHASE);

  // Controller FSM: owns the phase counter, the pending-halt flag and the
  // registered status outputs. Transitions out of RUN/STEP happen only on a
  // wrap, so a processor period is never cut short by a request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= RESET_STATE;
      phase_reg     <= '0;
      halt_pend_reg <= 1'b0;
      halted_reg    <= ~START_RUN;
      step_done_reg <= 1'b0;
    end else begin
      step_done_reg <= 1'b0;
      case (state_reg)
        ST_HALT: begin
          // Frozen with proc_clock high; halt has priority over run over step.
          phase_reg <= '0;
          if (!halt_req && run_req) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
          end else if (!halt_req && step_req) begin
            state_reg  <= ST_STEP;
            halted_reg <= 1'b0;
          end
        end

        ST_RUN: begin
          phase_reg <= phase_reg + LOG2DIV'(1);
          // A halt request seen in the wrap cycle itself stops at this wrap
          // without first being parked in halt_pend.
          if (wrap && (halt_pend_reg || halt_req)) begin
            state_reg     <= ST_HALT;
            halted_reg    <= 1'b1;
            halt_pend_reg <= 1'b0;
          end else if (halt_req) begin
            halt_pend_reg <= 1'b1;
          end
        end

        ST_STEP: begin
          // Exactly one period, then back to HALT; requests are not looked at.
          phase_reg <= phase_reg + LOG2DIV'(1);
          if (wrap) begin
            state_reg     <= ST_HALT;
            halted_reg    <= 1'b1;
            step_done_reg <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: park safely in HALT.
          state_reg     <= ST_HALT;
          halted_reg    <= 1'b1;
          phase_reg     <= '0;
          halt_pend_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef PCC_CYCLE_COUNT_EN
  logic [31:0] cycle_count_reg;

  // Counts completed processor periods; free-running 32-bit wrap, held in HALT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count_reg <= 32'd0;
    end else if (wrap) begin
      cycle_count_reg <= cycle_count_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`endif

  // proc_clock is a single registered bit (MSB of phase) inverted, so it can
  // not glitch: high in the first half of the period, rising at the wrap.
  assign proc_clock    = ~phase_reg[LOG2DIV-1];
  assign regfile_clock = ~phase_reg[LOG2DIV-1];
  assign phase         = phase_reg;
  assign halted        = halted_reg;
  assign step_done     = step_done_reg;

endmodule

// File: tb/tb_proc_clock_ctrl.sv
// tb_proc_clock_ctrl
//   Table-driven vectors for the basic run/halt/step sequences, hand-written
//   sequences for asynchronous reset and held step_req, then randomized
//   requests checked against a period-level reference model.
module tb_proc_clock_ctrl;

  localparam int DIV     = 4;
  localparam int LOG2DIV = 2;

  logic               clock    = 1'b0;
  logic               reset    = 1'b1;
  logic               run_req  = 1'b0;
  logic               halt_req = 1'b0;
  logic               step_req = 1'b0;
  logic               proc_clock;
  logic               regfile_clock;
  logic [LOG2DIV-1:0] phase;
  logic               halted;
  logic               step_done;
`ifdef PCC_CYCLE_COUNT_EN
  logic [31:0]        cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  proc_clock_ctrl #(
    .DIV      (DIV),
    .LOG2DIV  (LOG2DIV),
    .START_RUN(1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run_req      (run_req),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .proc_clock   (proc_clock),
    .regfile_clock(regfile_clock),
    .phase        (phase),
    .halted       (halted),
    .step_done    (step_done)
`ifdef PCC_CYCLE_COUNT_EN
    ,
    .cycle_count  (cycle_count)
`endif
  );

  // Independent count of processor clock rising edges seen on the DUT output.
  int rise_cnt = 0;
  always @(posedge proc_clock) rise_cnt++;

  // ---------------- reference model (period level) ----------------
  // mode: 0 = halted, 1 = free running, 2 = single step
  int          m_mode;
  int          m_pos;    // master cycles elapsed in the current period
  bit          m_pend;
  bit          m_done;
  int unsigned m_cnt;    // completed periods
  int          m_wraps;

  task automatic model_reset();
    m_mode = 1;
    m_pos  = 0;
    m_pend = 0;
    m_done = 0;
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    bit period_end;
    if (!reset) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_pos  = 0;
      m_done = 0;
      if (!halt_req && run_req)       m_mode = 1;
      else if (!halt_req && step_req) m_mode = 2;
    end else begin
      period_end = (m_pos == DIV - 1);
      m_pos  = (m_pos + 1) % DIV;
      m_done = 0;
      if (period_end) begin
        m_cnt++;
        m_wraps++;
      end
      if (m_mode == 1) begin
        if (halt_req) m_pend = 1;
        if (period_end && m_pend) begin
          m_mode = 0;
          m_pend = 0;
        end
      end else if (period_end) begin
        m_mode = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic exp_clk;
    exp_clk = (m_pos < DIV / 2);
    check({tag, ".phase"},  32'(phase),         32'(m_pos));
    check({tag, ".pclk"},   32'(proc_clock),    32'(exp_clk));
    check({tag, ".rfclk"},  32'(regfile_clock), 32'(exp_clk));
    check({tag, ".halted"}, 32'(halted),        32'(m_mode == 0));
    check({tag, ".done"},   32'(step_done),     32'(m_done));
`ifdef PCC_CYCLE_COUNT_EN
    check({tag, ".count"},  cycle_count,        m_cnt);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       run;
    logic       halt;
    logic       step;
    logic [1:0] ph;
    logic       clk;
    logic       hlt;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic h, logic s, logic [1:0] p,
                              logic c, logic hl, logic d);
    vec_t v;
    v.run = r; v.halt = h; v.step = s; v.ph = p; v.clk = c; v.hlt = hl; v.done = d;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int w0;
    int dones;
    bit got_halt;

    m_wraps = 0;
    model_reset();

    // Free run from reset, halt requested at phase 1, single step, then
    // halt+run together (halt wins) and finally run alone.
    vecs.push_back(mk(0,0,0, 2'd1, 1,0,0));
    vecs.push_back(mk(0,0,0, 2'd2, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd3, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd0, 1,0,0));
    vecs.push_back(mk(0,0,0, 2'd1, 1,0,0));
    vecs.push_back(mk(0,1,0, 2'd2, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd3, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd0, 1,1,0));
    vecs.push_back(mk(0,0,0, 2'd0, 1,1,0));
    vecs.push_back(mk(0,0,1, 2'd0, 1,0,0));
    vecs.push_back(mk(0,0,0, 2'd1, 1,0,0));
    vecs.push_back(mk(0,0,0, 2'd2, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd3, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd0, 1,1,1));
    vecs.push_back(mk(0,0,0, 2'd0, 1,1,0));
    vecs.push_back(mk(1,1,0, 2'd0, 1,1,0));
    vecs.push_back(mk(1,1,0, 2'd0, 1,1,0));
    vecs.push_back(mk(1,0,0, 2'd0, 1,0,0));
    vecs.push_back(mk(0,0,0, 2'd1, 1,0,0));
    vecs.push_back(mk(0,0,0, 2'd2, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd3, 0,0,0));
    vecs.push_back(mk(0,0,0, 2'd0, 1,0,0));

    // Reset held low for three master cycles.
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst.phase",  32'(phase),         32'd0);
    check("rst.pclk",   32'(proc_clock),    32'd1);
    check("rst.rfclk",  32'(regfile_clock), 32'd1);
    check("rst.halted", 32'(halted),        32'd0);
    check("rst.done",   32'(step_done),     32'd0);
`ifdef PCC_CYCLE_COUNT_EN
    check("rst.count",  cycle_count,        32'd0);
`endif
    $display("reset: phase=%0d pclk=%0b halted=%0b", phase, proc_clock, halted);
    reset = 1'b1;

    // Table vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      run_req  = vecs[i].run;
      halt_req = vecs[i].halt;
      step_req = vecs[i].step;
      tick();
      check($sformatf("vec%0d.phase", i),  32'(phase),         32'(vecs[i].ph));
      check($sformatf("vec%0d.pclk", i),   32'(proc_clock),    32'(vecs[i].clk));
      check($sformatf("vec%0d.rfclk", i),  32'(regfile_clock), 32'(vecs[i].clk));
      check($sformatf("vec%0d.halted", i), 32'(halted),        32'(vecs[i].hlt));
      check($sformatf("vec%0d.done", i),   32'(step_done),     32'(vecs[i].done));
      $display("vec %0d: run=%0b halt=%0b step=%0b -> phase=%0d pclk=%0b halted=%0b done=%0b",
               i, vecs[i].run, vecs[i].halt, vecs[i].step, phase, proc_clock, halted, step_done);
    end
    run_req = 0; halt_req = 0; step_req = 0;

    // Asynchronous reset in the middle of a RUN period (phase 2).
    tick();
    tick();
    check("mid.phase_before", 32'(phase), 32'd2);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("arst.phase",  32'(phase),      32'd0);
    check("arst.pclk",   32'(proc_clock), 32'd1);
    check("arst.halted", 32'(halted),     32'd0);
    check("arst.done",   32'(step_done),  32'd0);
    $display("async reset mid-period: phase=%0d pclk=%0b", phase, proc_clock);
    tick();
    tick();
    reset = 1'b1;
    r0 = rise_cnt;
    for (int i = 0; i < 3; i++) tick();
    check("arst.no_early_rise", 32'(rise_cnt - r0), 32'd0);
    check("arst.phase3",        32'(phase),         32'd3);
    tick();
    check("arst.first_rise",    32'(rise_cnt - r0), 32'd1);
    $display("post-reset first rise after %0d clocks", DIV);

    // Halt, then hold step_req high: back-to-back single steps.
    halt_req = 1'b1;
    got_halt = 0;
    for (int i = 0; i < 10 && !got_halt; i++) begin
      tick();
      got_halt = halted;
    end
    check("halt.reached", 32'(got_halt), 32'd1);
    halt_req = 1'b0;
    tick();
    check("halt.hold", 32'(halted), 32'd1);
    step_req = 1'b1;
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      dones += int'(step_done);
      check($sformatf("hstep%0d.done", k),   32'(step_done), 32'((k % 5) == 0));
      check($sformatf("hstep%0d.halted", k), 32'(halted),    32'((k % 5) == 0));
      $display("held step %0d: phase=%0d halted=%0b done=%0b", k, phase, halted, step_done);
    end
    step_req = 1'b0;
    check("hstep.pulses", 32'(dones), 32'd2);
    tick();
    check_model("hstep.after");

`ifdef PCC_CYCLE_COUNT_EN
    // Ten RUN periods, halt at the tenth wrap, one step: eleven periods.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      halt_req = (i == 39);
      tick();
    end
    halt_req = 1'b0;
    check("cnt.halted", 32'(halted), 32'd1);
    check("cnt.ten",    cycle_count, 32'd10);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("cnt.eleven", cycle_count, 32'd11);
    for (int i = 0; i < 3; i++) tick();
    check("cnt.hold",   cycle_count, 32'd11);
    check_model("cnt.model");
    $display("cycle_count after 10 run periods + 1 step: %0d", cycle_count);
`endif

    // Randomized requests against the reference model.
    r0 = rise_cnt;
    w0 = m_wraps;
    for (int i = 0; i < 400; i++) begin
      halt_req = ($urandom_range(0, 9) == 0);
      run_req  = ($urandom_range(0, 3) == 0);
      step_req = ($urandom_range(0, 2) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
      $display("rnd %0d: r=%0b h=%0b s=%0b -> phase=%0d halted=%0b done=%0b",
               i, run_req, halt_req, step_req, phase, halted, step_done);
    end
    check("rnd.rises", 32'(rise_cnt - r0), 32'(m_wraps - w0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
